// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches, masks and prioritises NUM_SRC request
// lines into the CPU's 6-bit itr vector. Define IRQ_SYNC_EN to add a 2-flop input synchroniser.
module irq_ctrl #(
    parameter int unsigned NUM_SRC   = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        addr,
    input  logic               we,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               sel,
    output logic [5:0]         itr,
    output logic               irq_any
);

    localparam int unsigned ITR_W     = 6;
    localparam int unsigned ITR_N     = (NUM_SRC < ITR_W) ? NUM_SRC : ITR_W;
    localparam int unsigned WIN_BYTES = 20;

    localparam logic [2:0] REG_PEND = 3'd0;
    localparam logic [2:0] REG_MASK = 3'd1;
    localparam logic [2:0] REG_MODE = 3'd2;
    localparam logic [2:0] REG_ACK  = 3'd3;
    localparam logic [2:0] REG_EOI  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_SERV = 2'd2
    } src_state_e;

    src_state_e         state_q [NUM_SRC];
    src_state_e         state_d [NUM_SRC];
    logic [NUM_SRC-1:0] repend_q, repend_d;
    logic [NUM_SRC-1:0] mask_q, mode_q, prev_q;
    logic [NUM_SRC-1:0] src_s, trig, pend_vec, act;
    logic [31:0]        off;
    logic [2:0]         reg_idx;
    logic [2:0]         wr_id;
    logic               wr_en, w1c_wr, mask_wr, mode_wr, ack_wr, eoi_wr;
    logic               ack_valid;
    logic [2:0]         ack_id;
    logic               unused_bits;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    // Two-stage synchroniser for asynchronous request lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end
    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    // Address window decode; low two address bits are ignored
    assign off     = addr - BASE_ADDR;
    assign sel     = (addr >= BASE_ADDR) && (off < 32'(WIN_BYTES));
    assign reg_idx = off[4:2];
    assign wr_id   = wdata[2:0];
    assign wr_en   = we & sel;
    assign w1c_wr  = wr_en && (reg_idx == REG_PEND);
    assign mask_wr = wr_en && (reg_idx == REG_MASK);
    assign mode_wr = wr_en && (reg_idx == REG_MODE);
    assign ack_wr  = wr_en && (reg_idx == REG_ACK);
    assign eoi_wr  = wr_en && (reg_idx == REG_EOI);

    assign unused_bits = ^wdata[31:NUM_SRC];

    // Level mode triggers on high; edge mode needs a 0->1 against prev
    assign trig = src_s & ~(mode_q & prev_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= S_IDLE;
            end
            repend_q <= '0;
            mask_q   <= '0;
            mode_q   <= '0;
            prev_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= state_d[i];
            end
            repend_q <= repend_d;
            prev_q   <= src_s;
            if (mask_wr) mask_q <= wdata[NUM_SRC-1:0];
            if (mode_wr) mode_q <= wdata[NUM_SRC-1:0];
        end
    end

    // Per-source IDLE/PEND/SERV next state with ACK/EOI handshake
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            state_d[i]  = state_q[i];
            repend_d[i] = repend_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (trig[i]) state_d[i] = S_PEND;
                end
                S_PEND: begin
                    if (ack_wr && (wr_id == 3'(i))) begin
                        state_d[i] = S_SERV;
                    end else if (w1c_wr && wdata[i] && !trig[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
                S_SERV: begin
                    if (eoi_wr && (wr_id == 3'(i))) begin
                        repend_d[i] = 1'b0;
                        state_d[i]  = (repend_q[i] || trig[i]) ? S_PEND : S_IDLE;
                    end else if (trig[i] && mode_q[i]) begin
                        repend_d[i] = 1'b1;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Pending vector, masked view and lowest-index priority pick
    always_comb begin
        pend_vec  = '0;
        ack_valid = 1'b0;
        ack_id    = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pend_vec[i] = (state_q[i] == S_PEND);
        end
        act = pend_vec & mask_q;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                ack_valid = 1'b1;
                ack_id    = 3'(i);
            end
        end
    end

    always_comb begin
        itr = '0;
        for (int i = 0; i < ITR_N; i++) begin
            itr[i] = act[i];
        end
    end

    assign irq_any = |itr;

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_idx)
                REG_PEND: rdata[NUM_SRC-1:0] = pend_vec;
                REG_MASK: rdata[NUM_SRC-1:0] = mask_q;
                REG_MODE: rdata[NUM_SRC-1:0] = mode_q;
                REG_ACK:  rdata = {ack_valid, 28'd0, ack_id};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected values are queued as stimulus is applied
// and popped when the corresponding bus read or itr sample is taken.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_7F20;
    localparam logic [31:0] A_PEND = BASE + 32'h00;
    localparam logic [31:0] A_MASK = BASE + 32'h04;
    localparam logic [31:0] A_MODE = BASE + 32'h08;
    localparam logic [31:0] A_ACK  = BASE + 32'h0C;
    localparam logic [31:0] A_EOI  = BASE + 32'h10;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_src;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic [5:0]  itr;
    logic        irq_any;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];

    irq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .sel     (sel),
        .itr     (itr),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus read: expectation is queued, then popped against the sampled rdata
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        addr = a;
        we   = 1'b0;
        #1;
        check(tag, rdata, exp_q.pop_front());
    endtask

    task automatic itr_chk(input string tag, input logic [5:0] e);
        exp_q.push_back({25'd0, |e, e});
        #1;
        check(tag, {25'd0, irq_any, itr}, exp_q.pop_front());
    endtask

    task automatic sel_chk(input string tag, input logic [31:0] a, input logic e);
        exp_q.push_back({31'd0, e});
        addr = a;
        we   = 1'b0;
        #1;
        check(tag, {31'd0, sel}, exp_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic settle();
        repeat (SYNC_LAT) @(negedge clk);
    endtask

    task automatic pulse(input logic [5:0] m);
        @(negedge clk);
        irq_src = irq_src | m;
        @(negedge clk);
        irq_src = irq_src & ~m;
        settle();
    endtask

    task automatic set_src(input logic [5:0] m, input logic v);
        @(negedge clk);
        irq_src = v ? (irq_src | m) : (irq_src & ~m);
        @(negedge clk);
        settle();
    endtask

    initial begin
        reset   = 1'b1;
        irq_src = '0;
        addr    = '0;
        we      = 1'b0;
        wdata   = '0;
        repeat (2) @(negedge clk);
        itr_chk("rst_itr", 6'h00);
        rd_chk("rst_mask", A_MASK, 32'h0);
        rd_chk("rst_pend", A_PEND, 32'h0);
        reset = 1'b0;

        // Single level pulse on src1
        wr(A_MASK, 32'h3F);
        rd_chk("mask_rb", A_MASK, 32'h3F);
        pulse(6'h02);
        rd_chk("p1_pend", A_PEND, 32'h02);
        itr_chk("p1_itr", 6'h02);
        rd_chk("p1_ack", A_ACK, 32'h8000_0001);
        wr(A_PEND, 32'h02);
        rd_chk("p1_w1c", A_PEND, 32'h0);
        itr_chk("p1_itr0", 6'h00);
        rd_chk("idle_ack", A_ACK, 32'h0);

        // Priority between src0 and src2
        pulse(6'h05);
        rd_chk("pr_pend", A_PEND, 32'h05);
        rd_chk("pr_ack", A_ACK, 32'h8000_0000);
        wr(A_ACK, 32'd0);
        itr_chk("pr_itr", 6'h04);
        rd_chk("pr_ack2", A_ACK, 32'h8000_0002);
        wr(A_EOI, 32'd0);
        rd_chk("pr_eoi", A_PEND, 32'h04);
        wr(A_PEND, 32'h04);
        rd_chk("pr_clr", A_PEND, 32'h0);

        // Edge mode on src1 with re-pend during service
        wr(A_MODE, 32'h02);
        rd_chk("mode_rb", A_MODE, 32'h02);
        pulse(6'h02);
        itr_chk("ed_itr", 6'h02);
        wr(A_ACK, 32'd1);
        itr_chk("ed_serv", 6'h00);
        pulse(6'h02);
        itr_chk("ed_rep", 6'h00);
        wr(A_EOI, 32'd1);
        rd_chk("ed_eoi", A_PEND, 32'h02);
        itr_chk("ed_itr2", 6'h02);
        wr(A_ACK, 32'd1);
        wr(A_EOI, 32'd1);
        rd_chk("ed_idle", A_PEND, 32'h0);
        set_src(6'h02, 1'b1);
        rd_chk("ed_hold", A_PEND, 32'h02);
        wr(A_ACK, 32'd1);
        wr(A_EOI, 32'd1);
        rd_chk("ed_noedge", A_PEND, 32'h0);
        set_src(6'h02, 1'b0);

        // Level src2 held high
        wr(A_MODE, 32'h0);
        set_src(6'h04, 1'b1);
        rd_chk("lv_pend", A_PEND, 32'h04);
        wr(A_ACK, 32'd2);
        rd_chk("lv_serv", A_PEND, 32'h0);
        wr(A_EOI, 32'd2);
        rd_chk("lv_repend", A_PEND, 32'h04);
        wr(A_PEND, 32'h04);
        rd_chk("lv_w1c_trig", A_PEND, 32'h04);
        set_src(6'h04, 1'b0);
        wr(A_PEND, 32'h04);
        rd_chk("lv_clr", A_PEND, 32'h0);
        itr_chk("lv_itr", 6'h00);

        // Ignored operations
        pulse(6'h01);
        wr(A_ACK, 32'd7);
        rd_chk("ig_ack7", A_PEND, 32'h01);
        wr(A_ACK, 32'd6);
        rd_chk("ig_ack6", A_PEND, 32'h01);
        wr(A_EOI, 32'd3);
        rd_chk("ig_eoi", A_PEND, 32'h01);
        wr(A_ACK, 32'd0);
        wr(A_PEND, 32'h01);
        set_src(6'h01, 1'b1);
        wr(A_EOI, 32'd0);
        rd_chk("ig_w1c_serv", A_PEND, 32'h01);
        set_src(6'h01, 1'b0);
        wr(A_PEND, 32'h01);
        rd_chk("ig_clr", A_PEND, 32'h0);

        // Window decode
        sel_chk("sel_in", A_EOI, 1'b1);
        sel_chk("sel_hi", BASE + 32'h14, 1'b0);
        sel_chk("sel_lo", BASE - 32'h4, 1'b0);
        rd_chk("out_rd", BASE + 32'h14, 32'h0);
        rd_chk("misalign", BASE + 32'h06, 32'h3F);
        rd_chk("eoi_rd", A_EOI, 32'h0);

        // Reset mid-service
        pulse(6'h01);
        wr(A_ACK, 32'd0);
        pulse(6'h08);
        itr_chk("pre_rst", 6'h08);
        @(negedge clk);
        reset = 1'b1;
        itr_chk("mr_itr", 6'h00);
        rd_chk("mr_mask", A_MASK, 32'h0);
        rd_chk("mr_pend", A_PEND, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        rd_chk("post_mode", A_MODE, 32'h0);
        itr_chk("post_itr", 6'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
